// File: rtl/mux4to1_rr_pkg.sv
// Shared types, constants and the round-robin pick function for the 4:1 merge path.
package mux_pkg;

    localparam int NUM_CH = 4;
    localparam int SEL_W  = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    typedef struct packed {
        logic             found;
        logic [SEL_W-1:0] idx;
    } pick_t;

    // Scan ptr+1 .. ptr+4 (mod 4); the pointer's own channel is looked at last.
    function automatic pick_t rr_pick(input logic [NUM_CH-1:0] valid,
                                      input logic [SEL_W-1:0]  ptr);
        pick_t r;
        r.found = 1'b0;
        r.idx   = '0;
        for (int k = 1; k <= NUM_CH; k++) begin
            logic [SEL_W-1:0] c;
            c = ptr + SEL_W'(k);
            if (!r.found && valid[c]) begin
                r.found = 1'b1;
                r.idx   = c;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/mux4to1_rr_arb4.sv
// Round-robin pointer register plus winner selection. When upd_i is high the
// pointer moves to upd_ptr_i and the winner is already computed from that new
// pointer, so the top can re-grant in the same cycle a burst ends.
module rr_arb4
    import mux_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] valid_i,
    input  logic              upd_i,
    input  logic [SEL_W-1:0]  upd_ptr_i,
    output logic [SEL_W-1:0]  winner_o,
    output logic              found_o
);

    logic [SEL_W-1:0] rr_ptr_q;
    logic [SEL_W-1:0] rr_ptr_d;
    pick_t            pick;

    // Effective pointer for this cycle and the winner it implies.
    always_comb begin
        rr_ptr_d = upd_i ? upd_ptr_i : rr_ptr_q;
        pick     = rr_pick(valid_i, rr_ptr_d);
        winner_o = pick.idx;
        found_o  = pick.found;
    end

    // Pointer starts at 3 so channel 0 has first priority out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_q <= 2'd3;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

endmodule

// File: rtl/mux4to1_rr.sv
// Four-channel round-robin merge onto a single registered valid/ready stream.
// Each output beat carries the 2-bit source channel in out_sel.
module mux4to1_rr
    import mux_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int BURST  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] in_valid,
    input  logic [DATA_W-1:0] in_data0,
    input  logic [DATA_W-1:0] in_data1,
    input  logic [DATA_W-1:0] in_data2,
    input  logic [DATA_W-1:0] in_data3,
    output logic [NUM_CH-1:0] in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic [SEL_W-1:0]  out_sel,
    input  logic              out_ready
);

    localparam int                CNT_W = $clog2(BURST) + 1;
    localparam logic [CNT_W-1:0]  LAST  = CNT_W'(BURST - 1);

    state_e            state_q, state_d;
    logic [SEL_W-1:0]  owner_q, owner_d;
    logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;
    logic              out_valid_q;
    logic [DATA_W-1:0] out_data_q;
    logic [SEL_W-1:0]  out_sel_q;

    logic              space;
    logic              owner_vld;
    logic              xfer;
    logic              rearb;
    logic [SEL_W-1:0]  winner;
    logic              found;
    logic [DATA_W-1:0] owner_data;

    rr_arb4 u_arb (
        .clk       (clk),
        .rst       (rst),
        .valid_i   (in_valid),
        .upd_i     (rearb),
        .upd_ptr_i (owner_q),
        .winner_o  (winner),
        .found_o   (found)
    );

    // Handshake qualifiers and the one-hot ready toward the current owner.
    always_comb begin
        space     = ~out_valid_q | out_ready;
        owner_vld = in_valid[owner_q];
        xfer      = (state_q == GRANT) & space & owner_vld;
        in_ready  = '0;
        if (state_q == GRANT && space) begin
            in_ready[owner_q] = 1'b1;
        end
    end

    // Select the owner's data for loading into the output register.
    always_comb begin
        case (owner_q)
            2'd0:    owner_data = in_data0;
            2'd1:    owner_data = in_data1;
            2'd2:    owner_data = in_data2;
            default: owner_data = in_data3;
        endcase
    end

    // Next-state: grant, count beats, and re-arbitrate at burst end or on drop.
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        beat_cnt_d = beat_cnt_q;
        rearb      = 1'b0;
        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d    = GRANT;
                    owner_d    = winner;
                    beat_cnt_d = '0;
                end
            end
            GRANT: begin
                if (!owner_vld) begin
                    rearb = 1'b1;
                end else if (space) begin
                    if (beat_cnt_q == LAST) begin
                        rearb = 1'b1;
                    end else begin
                        beat_cnt_d = beat_cnt_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (rearb) begin
            beat_cnt_d = '0;
            if (found) begin
                state_d = GRANT;
                owner_d = winner;
            end else begin
                state_d = IDLE;
            end
        end
    end

    // Control state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            owner_q    <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    // Single-entry output register; data/sel hold after the beat drains.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= '0;
        end else if (xfer) begin
            out_valid_q <= 1'b1;
            out_data_q  <= owner_data;
            out_sel_q   <= owner_q;
        end else if (out_valid_q && out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_mux4to1_rr.sv
// Directed and randomized-loopback bench for the 4:1 round-robin merge.
module tb_mux4to1_rr;

    logic       clk;
    logic       rst;
    logic [3:0] in_valid;
    logic [7:0] in_data0, in_data1, in_data2, in_data3;
    logic [3:0] in_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic [1:0] out_sel;
    logic       out_ready;

    mux4to1_rr #(.DATA_W(8), .BURST(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data0  (in_data0),
        .in_data1  (in_data1),
        .in_data2  (in_data2),
        .in_data3  (in_data3),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    logic [7:0] src_q [4][$];
    logic [7:0] exp_q [4][$];
    logic [1:0] obs_sel [$];
    logic [7:0] obs_data [$];
    int         obs_cyc [$];
    logic [3:0] offer;
    logic [3:0] en;
    logic       rnd;
    logic [3:0] fire_m;
    int         cyc;
    int         onehot_err;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Monitor: inputs are stable from posedge+1 to the next posedge, so the
    // negedge view is exactly what the next rising edge will act on.
    initial begin
        cyc = 0;
        onehot_err = 0;
        fire_m = '0;
    end
    always @(negedge clk) begin
        if (rst) begin
            fire_m <= '0;
        end else begin
            if (out_valid && out_ready) begin
                obs_sel.push_back(out_sel);
                obs_data.push_back(out_data);
                obs_cyc.push_back(cyc);
            end
            fire_m <= in_valid & in_ready;
            if ($countones(in_ready) > 1) onehot_err <= onehot_err + 1;
            cyc <= cyc + 1;
        end
    end

    task automatic drive();
        logic [7:0] dat [4];
        for (int k = 0; k < 4; k++) begin
            dat[k] = (offer[k] && src_q[k].size() > 0) ? src_q[k][0] : 8'h00;
        end
        in_valid = offer;
        in_data0 = dat[0];
        in_data1 = dat[1];
        in_data2 = dat[2];
        in_data3 = dat[3];
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            if (fire_m[k]) begin
                if (src_q[k].size() > 0) void'(src_q[k].pop_front());
                if (rnd) offer[k] = 1'b0;
            end
        end
        for (int k = 0; k < 4; k++) begin
            if (rnd) begin
                if (!offer[k] && src_q[k].size() > 0 && $urandom_range(0, 1) == 1) offer[k] = 1'b1;
            end else begin
                offer[k] = en[k] && (src_q[k].size() > 0);
            end
        end
        if (rnd) out_ready = ($urandom_range(0, 3) != 0);
        drive();
    endtask

    task automatic clear_all();
        for (int k = 0; k < 4; k++) begin
            src_q[k].delete();
            exp_q[k].delete();
        end
        offer = '0;
        en = '0;
        rnd = 1'b0;
        drive();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        out_ready = 1'b0;
        clear_all();
        repeat (2) @(posedge clk);
        #1;
        obs_sel.delete();
        obs_data.delete();
        obs_cyc.delete();
        rst = 1'b0;
    endtask

    task automatic run_until(input string tag, input int n, input int budget);
        int b;
        b = 0;
        while (obs_sel.size() < n && b < budget) begin
            advance();
            b++;
        end
        chk(tag, obs_sel.size(), n);
    endtask

    initial begin
        logic [7:0] held;
        logic [1:0] exp_sel [10];
        logic [7:0] exp_dat [10];
        int         got_n;
        int         b;
        logic [7:0] v;

        // Reset state, before any clock activity matters.
        rst = 1'b1;
        out_ready = 1'b0;
        clear_all();
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_sel", out_sel, 0);
        chk("rst_out_data", out_data, 0);
        do_reset();

        // Asynchronous reset while a beat is held in the output register.
        src_q[2].push_back(8'h55);
        en = 4'b0100;
        out_ready = 1'b0;
        offer = 4'b0100;
        drive();
        b = 0;
        while (!out_valid && b < 10) begin
            advance();
            b++;
        end
        chk("pre_rst_out_valid", out_valid, 1);
        chk("pre_rst_out_sel", out_sel, 2);
        chk("pre_rst_out_data", out_data, 8'h55);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_out_valid", out_valid, 0);
        chk("async_rst_in_ready", in_ready, 0);
        chk("async_rst_out_sel", out_sel, 0);
        chk("async_rst_out_data", out_data, 0);
        clear_all();
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (3) advance();
        chk("idle_out_valid", out_valid, 0);
        chk("idle_in_ready", in_ready, 0);

        // Single channel stream across the burst boundary.
        do_reset();
        for (int i = 0; i < 6; i++) src_q[2].push_back(8'hA0 + 8'(i));
        en = 4'b0100;
        out_ready = 1'b1;
        offer = 4'b0100;
        drive();
        run_until("t2_count", 6, 40);
        got_n = obs_sel.size();
        for (int i = 0; i < 6 && i < got_n; i++) begin
            chk($sformatf("t2_sel%0d", i), obs_sel[i], 2);
            chk($sformatf("t2_data%0d", i), obs_data[i], 8'hA0 + 8'(i));
            chk($sformatf("t2_gap%0d", i), obs_cyc[i] - obs_cyc[0], i);
        end

        // All four channels continuously valid: fairness order.
        do_reset();
        for (int k = 0; k < 4; k++)
            for (int i = 0; i < 8; i++) src_q[k].push_back(8'(k * 16 + i));
        en = 4'b1111;
        out_ready = 1'b1;
        offer = 4'b1111;
        drive();
        run_until("t3_count", 20, 60);
        got_n = obs_sel.size();
        for (int j = 0; j < 20 && j < got_n; j++) begin
            chk($sformatf("t3_sel%0d", j), obs_sel[j], (j / 4) % 4);
            chk($sformatf("t3_data%0d", j), obs_data[j], ((j / 4) % 4) * 16 + (j / 16) * 4 + (j % 4));
        end
        chk("t3_onehot", onehot_err, 0);

        // Backpressure mid-burst on channel 1, channel 3 waiting behind it.
        do_reset();
        for (int i = 0; i < 6; i++) src_q[1].push_back(8'h10 + 8'(i));
        for (int i = 0; i < 4; i++) src_q[3].push_back(8'h30 + 8'(i));
        en = 4'b1010;
        out_ready = 1'b1;
        offer = 4'b1010;
        drive();
        run_until("t4_pre", 2, 20);
        out_ready = 1'b0;
        held = out_data;
        chk("t4_held", held, 8'h12);
        for (int i = 0; i < 5; i++) begin
            advance();
            chk($sformatf("t4_stall_data%0d", i), out_data, 8'h12);
            chk($sformatf("t4_stall_sel%0d", i), out_sel, 1);
            chk($sformatf("t4_stall_rdy%0d", i), in_ready, 0);
            chk($sformatf("t4_stall_vld%0d", i), out_valid, 1);
        end
        out_ready = 1'b1;
        drive();
        run_until("t4_count", 10, 40);
        exp_sel = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd3, 2'd3, 2'd3, 2'd3, 2'd1, 2'd1};
        exp_dat = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h30, 8'h31, 8'h32, 8'h33, 8'h14, 8'h15};
        got_n = obs_sel.size();
        for (int j = 0; j < 10 && j < got_n; j++) begin
            chk($sformatf("t4_sel%0d", j), obs_sel[j], exp_sel[j]);
            chk($sformatf("t4_data%0d", j), obs_data[j], exp_dat[j]);
        end

        // Channel 3 drops valid after two beats; channel 0 takes over.
        do_reset();
        src_q[3].push_back(8'h30);
        src_q[3].push_back(8'h31);
        for (int i = 0; i < 3; i++) src_q[0].push_back(8'h00 + 8'(i));
        en = 4'b1000;
        out_ready = 1'b1;
        offer = 4'b1000;
        drive();
        advance();
        advance();
        en = 4'b1001;
        offer = en;
        drive();
        run_until("t5_count", 5, 30);
        exp_sel[0:4] = '{2'd3, 2'd3, 2'd0, 2'd0, 2'd0};
        exp_dat[0:4] = '{8'h30, 8'h31, 8'h00, 8'h01, 8'h02};
        got_n = obs_sel.size();
        for (int j = 0; j < 5 && j < got_n; j++) begin
            chk($sformatf("t5_sel%0d", j), obs_sel[j], exp_sel[j]);
            chk($sformatf("t5_data%0d", j), obs_data[j], exp_dat[j]);
        end
        chk("t5_ch3_left", src_q[3].size(), 0);

        // Loopback: per-channel scoreboard acting as the downstream demux.
        do_reset();
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 250; i++) begin
                v = 8'($urandom_range(0, 255));
                src_q[k].push_back(v);
                exp_q[k].push_back(v);
            end
        end
        rnd = 1'b1;
        out_ready = 1'b1;
        drive();
        got_n = 0;
        b = 0;
        while (got_n < 1000 && b < 20000) begin
            advance();
            b++;
            while (obs_sel.size() > 0) begin
                logic [1:0] s;
                logic [7:0] d;
                s = obs_sel.pop_front();
                d = obs_data.pop_front();
                void'(obs_cyc.pop_front());
                if (exp_q[s].size() == 0) begin
                    chk("lb_extra_beat", {30'd0, s}, 32'hFFFF_FFFF);
                end else begin
                    chk($sformatf("lb_ch%0d_y", s), d, exp_q[s].pop_front());
                end
                got_n++;
            end
        end
        chk("lb_total", got_n, 1000);
        for (int k = 0; k < 4; k++) chk($sformatf("lb_left%0d", k), exp_q[k].size(), 0);
        chk("lb_onehot", onehot_err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mux4to1_rr.md
Name: mux4to1_rr

Overview:
- Four-channel round-robin multiplexer; the merge-side counterpart of the 1:4 demultiplexer. It collects four valid/ready input streams onto one registered output stream.
- Tags each output beat with a 2-bit source select (out_sel), so a downstream DEMUX1x4 can route traffic back by channel.
- Sits between four independent producers and a single shared consumer.

Parameters:
DATA_W, 8, width of each data channel
BURST, 4, max consecutive beats granted to one channel before re-arbitration (1..16)

Ports:
clk  input  1  system clock, rising-edge
rst  input  1  asynchronous reset, active-high
in_valid  input  4  per-channel valid; bit k = channel k
in_data0  input  DATA_W  channel 0 data
in_data1  input  DATA_W  channel 1 data
in_data2  input  DATA_W  channel 2 data
in_data3  input  DATA_W  channel 3 data
in_ready  output  4  per-channel ready; at most one bit high
out_valid  output  1  output beat valid
out_data  output  DATA_W  output data
out_sel  output  2  source channel of out_data (sel1=bit1, sel0=bit0)
out_ready  input  1  consumer ready

Behaviour:
- One clock (clk); reset is asynchronous and active-high (rst). Async assert, sync-safe deassert assumed upstream.
- Reset values: out_valid=0, out_data=0, out_sel=0, in_ready=0, state=IDLE, owner=0, beat_cnt=0, rr_ptr=3. With rr_ptr=3, channel 0 has first priority.
- Handshake: a transfer occurs on a channel when valid & ready are both high at a rising edge. Valid must not depend on ready. Data is held stable while valid and not ready (required of producers, guaranteed on the output).
- Output register: single entry. space = ~out_valid | out_ready.
  - On an input transfer: load out_data/out_sel, set out_valid=1.
  - Else, if out_valid & out_ready: clear out_valid; out_data/out_sel hold their last value.
- in_ready[owner] = (state==GRANT) & space. All other bits are 0. The out_ready->in_ready combinational path is permitted; there are no other combinational in->out paths.
- Winner function: scan channels (rr_ptr+1, +2, +3, +4) mod 4 and pick the first with in_valid set. rr_ptr itself is scanned last.
- State machine:
  - IDLE: if any in_valid, go to GRANT; owner=winner, beat_cnt=0. Otherwise stay in IDLE. Latency is one cycle from valid to in_ready.
  - GRANT, with an owner transfer and beat_cnt==BURST-1: end of burst. Set rr_ptr=owner. If any in_valid, re-grant directly to the winner computed with the updated pointer (beat_cnt=0); else go to IDLE.
  - GRANT, with an owner transfer and beat_cnt<BURST-1: beat_cnt++, stay in GRANT.
  - GRANT, with in_valid[owner]==0: abandon the grant. Set rr_ptr=owner, then re-arbitrate as at end of burst in the same cycle. beat_cnt resets.
  - GRANT, with owner valid but no space: hold. Owner, beat_cnt and rr_ptr are unchanged.
- Re-grant: a channel that is the only requester after its burst is re-granted with no gap cycle. Full throughput is 1 beat/cycle while out_ready=1.
- Fairness: with all four channels continuously valid, the grant order is 0,1,2,3,0,... with BURST beats each.
- beat_cnt width: clog2(BURST)+1. No wrap, because it resets at BURST-1.
- Reset mid-burst: all state returns to reset values immediately. Any beat held in the output register is discarded; producers must re-present it.

Decomposition:
- Shared package (mux_pkg):
  - state enum {IDLE, GRANT}
  - NUM_CH=4 and SEL_W=2 constants
  - function rr_pick(valid[3:0], ptr[1:0]) returning the winner index plus a found flag; reused by demux-side tests.
- One sub-module is natural: rr_arb4 (round-robin pointer + winner logic). The mux datapath and output register stay in the top module.

Test Plan:
- Reset and idle: assert rst mid-run with out_valid=1 -> out_valid, in_ready, out_sel all 0 asynchronously. After release with in_valid=0, outputs stay 0.
- Single channel: in_valid=4'b0100, data 8'hA0..A5, out_ready=1 -> out_sel=2 on every beat. Data arrives in order with 1-cycle latency and no gaps across the BURST=4 boundary.
- All channels valid, out_ready=1, BURST=4 -> out_sel sequence 0,0,0,0,1,1,1,1,2,2,2,2,3,3,3,3,0...; in_ready is one-hot at all times.
- Backpressure: out_ready=0 for 5 cycles mid-burst on channel 1 -> out_data/out_sel stable, in_ready=0, beat_cnt frozen. After release the burst completes with exactly 4 channel-1 beats total.
- Early drop: channel 3 drops valid after 2 beats while channel 0 is valid -> the next out_sel is 0 and no channel-3 beat is lost or duplicated.
- Loopback: drive out_data/out_sel into DEMUX1x4 (sel0=out_sel[0], sel1=out_sel[1]) -> each channel's data appears on the matching y output, with 1000 random beats matched by a scoreboard.
